// File: rtl/pacman_pkg.sv
// Shared maze/ghost types: headings, reverse helper, fallback priority and the
// direction-selector FSM states. An exit-mask bit index equals the dir_t code.
package pacman_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   // Deterministic pick order when random draws keep missing, highest first.
   localparam dir_t FB_PRI [4] = '{DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT};

   typedef enum logic [1:0] {
      GDS_IDLE,
      GDS_DRAW,
      GDS_RESP
   } gds_state_t;

   function automatic dir_t dir_reverse(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/dir_fallback_pri.sv
// Priority pick of one open direction from a 4-bit exit mask (UP, LEFT, DOWN,
// RIGHT); none flags an empty mask.
module dir_fallback_pri
   import pacman_pkg::*;
(
   input  logic [3:0] allowed,
   output dir_t       dir,
   output logic       none
);

   // Walk lowest priority first so the highest-priority hit is written last.
   always_comb begin
      dir  = DIR_UP;
      none = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         if (allowed[FB_PRI[i]]) begin
            dir  = FB_PRI[i];
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ghost_dir_sel.sv
// Ghost heading picker: rejection-samples the LFSR stream against the junction
// exit mask, falling back to a fixed priority. GHOST_DIR_SEL_STATS_EN adds fallback_cnt.
module ghost_dir_sel
   import pacman_pkg::*;
#(
   parameter int MAX_TRIES = 8,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] rand_in,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] open_mask,
   input  logic [1:0] cur_dir,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_dir,
   output logic       rsp_fallback
`ifdef GHOST_DIR_SEL_STATS_EN
   ,
   output logic [7:0] fallback_cnt
`endif
);

   gds_state_t       state;
   logic [3:0]       mask_q;
   dir_t             dir_q;
   logic [CNT_W-1:0] try_cnt;
   logic [CNT_W-1:0] try_nxt;
   logic [3:0]       allowed;
   dir_t             cand;
   dir_t             fb_dir;
   logic             fb_none;
   logic             unused_rand;

   assign cand        = dir_t'(rand_in[1:0]);
   assign unused_rand = rand_in[2];
   assign try_nxt     = try_cnt + CNT_W'(1);

   // Never turn back unless the junction is a dead end.
   always_comb begin
      allowed                     = mask_q;
      allowed[dir_reverse(dir_q)] = 1'b0;
      if (allowed == 4'b0000)
         allowed = mask_q;
   end

   // fb_none is only possible when mask_q is empty (boxed in).
   dir_fallback_pri u_fb_pri (
      .allowed (allowed),
      .dir     (fb_dir),
      .none    (fb_none)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= GDS_IDLE;
         try_cnt      <= '0;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_dir      <= 2'd0;
         rsp_fallback <= 1'b0;
         mask_q       <= 4'b0000;
         dir_q        <= DIR_UP;
      end else begin
         case (state)
            GDS_IDLE: begin
               if (req_valid && req_ready) begin
                  mask_q    <= open_mask;
                  dir_q     <= dir_t'(cur_dir);
                  try_cnt   <= '0;
                  req_ready <= 1'b0;
                  state     <= GDS_DRAW;
               end
            end
            GDS_DRAW: begin
               if (fb_none) begin
                  rsp_dir      <= dir_q;
                  rsp_fallback <= 1'b1;
                  rsp_valid    <= 1'b1;
                  state        <= GDS_RESP;
               end else if (allowed[cand]) begin
                  rsp_dir      <= cand;
                  rsp_fallback <= 1'b0;
                  rsp_valid    <= 1'b1;
                  state        <= GDS_RESP;
               end else begin
                  try_cnt <= try_nxt;
                  if (try_nxt == CNT_W'(MAX_TRIES)) begin
                     rsp_dir      <= fb_dir;
                     rsp_fallback <= 1'b1;
                     rsp_valid    <= 1'b1;
                     state        <= GDS_RESP;
                  end
               end
            end
            GDS_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= GDS_IDLE;
               end
            end
            default: begin
               state     <= GDS_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef GHOST_DIR_SEL_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         fallback_cnt <= 8'd0;
      else if (rsp_valid && rsp_ready && rsp_fallback && fallback_cnt != 8'hFF)
         fallback_cnt <= fallback_cnt + 8'd1;
   end
`endif

endmodule

// File: doc/ghost_dir_sel.md
Name: ghost_dir_sel

Overview:
Consumer end of the game's LFSR random stream. Turns 3-bit pseudo-random samples into a legal ghost heading at a maze junction, using rejection sampling against a wall mask. Sits between the random source and each ghost's movement controller, one instance per ghost. Uses a valid/ready request/response handshake so movement logic can stall it.

Parameters:
MAX_TRIES, 8, random draws attempted before deterministic fallback; range 1..15.
CNT_W, 4, width of the internal try counter; must hold MAX_TRIES.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rand_in  in  3  free-running random sample; bits [1:0] are the candidate direction, bit [2] is unused
req_valid  in  1  junction decision requested
req_ready  out  1  block can accept a request (high only in IDLE)
open_mask  in  4  open exits, bit index = direction code; sampled on request handshake
cur_dir  in  2  ghost's current heading; sampled on request handshake
rsp_valid  out  1  rsp_dir/rsp_fallback valid
rsp_ready  in  1  consumer takes the response
rsp_dir  out  2  chosen direction
rsp_fallback  out  1  result came from fallback, not a random draw

Behaviour:
- Direction encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3. reverse(d) = d XOR 2.
- Reset (async, any state): state=IDLE, try counter=0, req_ready=1, rsp_valid=0, rsp_dir=0, rsp_fallback=0, captured mask/dir=0.
- FSM states: IDLE, DRAW, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture open_mask into mask_q and cur_dir into dir_q, clear the try counter, and go to DRAW.
- Legal-set rule: allowed = mask_q with bit reverse(dir_q) cleared. If allowed==0 (dead end), allowed = mask_q, so reverse is legal.
- DRAW, one draw per cycle: cand = rand_in[1:0].
  - If allowed[cand]: register rsp_dir=cand, rsp_fallback=0, go to RESP.
  - Else increment the try counter.
  - If the counter reaches MAX_TRIES without a hit: rsp_dir = first set bit of allowed in priority UP, LEFT, DOWN, RIGHT; rsp_fallback=1; go to RESP.
- mask_q==0 (boxed in) in DRAW: skip draws. rsp_dir=dir_q, rsp_fallback=1, go to RESP on the first DRAW cycle.
- Latency: handshake at cycle 0 → first draw at cycle 1 → rsp_valid high at cycle 2 in the best case. Worst case rsp_valid at cycle MAX_TRIES+1.
- RESP: rsp_valid=1. rsp_dir and rsp_fallback stay stable until rsp_valid&rsp_ready, then go to IDLE. req_ready rises the following cycle; no same-cycle re-accept.
- req_valid outside IDLE is ignored. open_mask and cur_dir changes after capture have no effect.
- rand_in is sampled combinationally each DRAW cycle. No handshake with the random source; it must advance every clock.

Optional Feature:
Macro GHOST_DIR_SEL_STATS_EN.
- Defined: adds output port fallback_cnt [7:0]. It increments on each response handshake with rsp_fallback=1, saturates at 255, and is cleared by reset_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pacman_pkg holds:
  - dir_t enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT, 2-bit)
  - dir_reverse function
  - the 4-bit exit-mask bit ordering
  - the fallback priority order
  - the FSM state enum for this block
- One natural combinational sub-module: dir_fallback_pri. It takes a 4-bit allowed mask and returns the priority-selected direction plus a none flag.

Test Plan:
- Reset mid-DRAW: assert reset_n=0 during a draw → next observed outputs are req_ready=1, rsp_valid=0, rsp_dir=0, rsp_fallback=0, with no response emitted.
- First-draw hit: mask=4'b1111, cur_dir=UP, rand_in=3'b001 held → rsp_valid at cycle 2 with rsp_dir=RIGHT, rsp_fallback=0.
- Reverse rejected then fallback: mask=4'b0101 (UP, DOWN open), cur_dir=UP, rand_in fixed at 2 (DOWN = reverse) → 8 rejected draws, then rsp_dir=UP, rsp_fallback=1 at cycle 9.
- Dead end: mask=4'b0100, cur_dir=UP, rand_in cycling 0,1,2 → rsp_dir=DOWN, rsp_fallback=0 at cycle 4.
- Boxed in: mask=0, cur_dir=LEFT → rsp_dir=LEFT, rsp_fallback=1 at cycle 2.
- Backpressure: rsp_ready low 5 cycles while rand_in varies → rsp_dir stable and req_ready=0 throughout. A new req_valid is accepted only after the rsp handshake. With GHOST_DIR_SEL_STATS_EN defined, 300 boxed-in requests leave fallback_cnt at 255.
